// File: rtl/cell_editor.sv
// cell_editor: keeps a cursor on the toroidal N x M board and performs single-cell
//   toggle (read-modify-write) / set writes and full-board clear sweeps on the board RAM.
// Latency: moves take effect on the accept edge; set writes on the next cycle; toggle
//   writes RD_LAT cycles after the read; sweep takes N*M cycles; done pulses one cycle later.
// Backpressure: cmd_ready = enable && IDLE; commands offered while not ready are dropped.
//
// Ports: clk/rst (async active-high), enable, cmd_valid/cmd/cmd_ready (command input),
//   ram_addr/ram_rden/ram_wren/ram_wdata/ram_rdata (board RAM), cursor_x/cursor_y
//   (VGA overlay), busy, done.
// Optional: define CELL_EDITOR_FILL_EN to make cmd 7 a random-fill sweep driven by a
//   24-bit Galois LFSR; otherwise cmd 7 is accepted and ignored.
module cell_editor #(
    parameter int P_PARAM_M   = 300,
    parameter int P_PARAM_N   = 400,
    parameter int COORD_WIDTH = 12,
    parameter int ADDR_WIDTH  = 24,
    parameter int RD_LAT      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   cmd_valid,
    input  logic [2:0]             cmd,
    output logic                   cmd_ready,
    output logic [ADDR_WIDTH-1:0]  ram_addr,
    output logic                   ram_rden,
    output logic                   ram_wren,
    output logic                   ram_wdata,
    input  logic                   ram_rdata,
    output logic [COORD_WIDTH-1:0] cursor_x,
    output logic [COORD_WIDTH-1:0] cursor_y,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_WAIT  = 3'd2,
        S_WR    = 3'd3,
        S_SWEEP = 3'd4
    } state_t;

    localparam logic [COORD_WIDTH-1:0] X_MAX     = COORD_WIDTH'(P_PARAM_N - 1);
    localparam logic [COORD_WIDTH-1:0] Y_MAX     = COORD_WIDTH'(P_PARAM_M - 1);
    localparam logic [ADDR_WIDTH-1:0]  N_ADDR    = ADDR_WIDTH'(P_PARAM_N);
    localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = ADDR_WIDTH'(P_PARAM_N * P_PARAM_M - 1);
    // WAIT lasts RD_LAT-1 cycles; the counter's final value is RD_LAT-2.
    localparam logic [1:0]             WAIT_LAST = 2'(RD_LAT - 2);

    state_t                 state_q, state_d;
    logic [COORD_WIDTH-1:0] cur_x_q, cur_x_d;
    logic [COORD_WIDTH-1:0] cur_y_q, cur_y_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   op_set_q, op_set_d;
    logic [1:0]             wait_cnt_q, wait_cnt_d;
    logic                   done_q, done_d;
`ifdef CELL_EDITOR_FILL_EN
    logic                   op_fill_q, op_fill_d;
    logic [23:0]            lfsr_q, lfsr_d;
`endif

    logic                  accept;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  sweep_last;

    assign accept     = cmd_valid && cmd_ready;
    // Full-width multiply so large boards never wrap the address.
    assign cur_addr   = ADDR_WIDTH'(cur_y_q) * N_ADDR + ADDR_WIDTH'(cur_x_q);
    assign sweep_last = (addr_q == LAST_ADDR);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (cmd)
                        3'd4:    state_d = S_RD;
                        3'd5:    state_d = S_WR;
                        3'd6:    state_d = S_SWEEP;
`ifdef CELL_EDITOR_FILL_EN
                        3'd7:    state_d = S_SWEEP;
`endif
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_RD:    state_d = (RD_LAT <= 1) ? S_WR : S_WAIT;
            S_WAIT:  state_d = (wait_cnt_q == WAIT_LAST) ? S_WR : S_WAIT;
            S_WR:    state_d = S_IDLE;
            S_SWEEP: state_d = sweep_last ? S_IDLE : S_SWEEP;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Strobes decode straight from the state register so an async reset drops them at once.
    always_comb begin
        cmd_ready = enable && (state_q == S_IDLE);
        ram_rden  = (state_q == S_RD);
        ram_wren  = (state_q == S_WR) || (state_q == S_SWEEP);
        busy      = (state_q != S_IDLE);
        ram_wdata = 1'b0;
        case (state_q)
            // Toggle: read data arrives exactly in the WR cycle, invert it on the fly.
            S_WR: ram_wdata = op_set_q ? 1'b1 : ~ram_rdata;
`ifdef CELL_EDITOR_FILL_EN
            S_SWEEP: ram_wdata = op_fill_q ? lfsr_q[0] : 1'b0;
`endif
            default: ram_wdata = 1'b0;
        endcase
    end

    assign ram_addr = addr_q;
    assign cursor_x = cur_x_q;
    assign cursor_y = cur_y_q;
    assign done     = done_q;

    // ---------------- Datapath next state ----------------
    always_comb begin
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        addr_d     = addr_q;
        op_set_d   = op_set_q;
        wait_cnt_d = wait_cnt_q;
        done_d     = 1'b0;
`ifdef CELL_EDITOR_FILL_EN
        op_fill_d  = op_fill_q;
        lfsr_d     = lfsr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (cmd)
                        3'd0: cur_y_d = (cur_y_q == '0)    ? Y_MAX : cur_y_q - 1'b1;
                        3'd1: cur_y_d = (cur_y_q == Y_MAX) ? '0    : cur_y_q + 1'b1;
                        3'd2: cur_x_d = (cur_x_q == '0)    ? X_MAX : cur_x_q - 1'b1;
                        3'd3: cur_x_d = (cur_x_q == X_MAX) ? '0    : cur_x_q + 1'b1;
                        3'd4: begin
                            addr_d   = cur_addr;
                            op_set_d = 1'b0;
                        end
                        3'd5: begin
                            addr_d   = cur_addr;
                            op_set_d = 1'b1;
                        end
                        3'd6: begin
                            addr_d = '0;
`ifdef CELL_EDITOR_FILL_EN
                            op_fill_d = 1'b0;
`endif
                        end
                        default: begin
`ifdef CELL_EDITOR_FILL_EN
                            addr_d    = '0;
                            op_fill_d = 1'b1;
`endif
                        end
                    endcase
                end
            end
            S_RD:   wait_cnt_d = '0;
            S_WAIT: wait_cnt_d = wait_cnt_q + 1'b1;
            S_WR:   done_d = 1'b1;
            S_SWEEP: begin
`ifdef CELL_EDITOR_FILL_EN
                // Galois form, taps 24,23,22,17; keeps running across fills.
                lfsr_d = {1'b0, lfsr_q[23:1]} ^ (lfsr_q[0] ? 24'hE10000 : 24'h000000);
`endif
                if (sweep_last) begin
                    done_d = 1'b1;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            addr_q     <= '0;
            op_set_q   <= 1'b0;
            wait_cnt_q <= '0;
            done_q     <= 1'b0;
`ifdef CELL_EDITOR_FILL_EN
            op_fill_q  <= 1'b0;
            lfsr_q     <= 24'h000001;
`endif
        end else begin
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            addr_q     <= addr_d;
            op_set_q   <= op_set_d;
            wait_cnt_q <= wait_cnt_d;
            done_q     <= done_d;
`ifdef CELL_EDITOR_FILL_EN
            op_fill_q  <= op_fill_d;
            lfsr_q     <= lfsr_d;
`endif
        end
    end

endmodule
